// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the execute-to-memory boundary: branch condition codes,
// write-back source encodings and the squash FSM state type.
package ex_mem_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Write-back source encodings, shared with decode.
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;
    localparam logic [1:0] WB_SEL_CSR = 2'b11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } state_t;

endpackage

// File: rtl/ex_mem_stage_branch_cmp.sv
// Branch condition evaluation from the ALU flags; the ALU computes rs1 - rs2
// for branches, so the condition is a pure function of funct3 and the flags.
module branch_cmp
    import ex_mem_stage_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt_signed,
    input  logic       lt_unsigned,
    output logic       cond
);

    always_comb begin
        // NOTE: default assigned first so no path leaves cond unassigned (no latch).
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = zero;
            F3_BNE:  cond = ~zero;
            F3_BLT:  cond = lt_signed;
            F3_BGE:  cond = ~lt_signed;
            F3_BLTU: cond = lt_unsigned;
            F3_BGEU: cond = ~lt_unsigned;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: resolves branches and jumps, issues a one-cycle
// registered redirect and squashes the wrong-path instruction that follows.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] alu_out,
    input  logic            zero,
    input  logic            lt_signed,
    input  logic            lt_unsigned,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_we,
    input  logic            ex_mem_re,
    input  logic            ex_mem_we,
    input  logic [1:0]      ex_wb_sel,
    output logic            ex_accept,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_we,
    output logic            mem_mem_re,
    output logic            mem_mem_we,
    output logic [2:0]      mem_funct3,
    output logic [1:0]      mem_wb_sel,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    state_t          state_q, state_d;
    logic            cond;
    logic            ev;
    logic            is_jump;
    logic            taken;
    logic            side_fx_ok;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_addr;

    branch_cmp u_branch_cmp (
        .funct3      (ex_funct3),
        .zero        (zero),
        .lt_signed   (lt_signed),
        .lt_unsigned (lt_unsigned),
        .cond        (cond)
    );

    assign ex_accept = ~stall_in;
    assign ev        = ex_valid & ~flush & (state_q == ST_RUN);
    assign is_jump   = ex_is_jal | ex_is_jalr;
    assign taken     = ev & ((ex_is_branch & cond) | is_jump);
    assign target    = ex_is_jalr ? {alu_out[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
    assign link_addr = ex_pc + XLEN'(4);

    // A not-taken branch still retires, but must not write anything downstream.
    assign side_fx_ok = ev & ~(ex_is_branch & ~cond);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (taken && !stall_in) state_d = ST_KILL;
            ST_KILL: if (!stall_in)          state_d = ST_RUN;
            default:                         state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_we     <= 1'b0;
            mem_mem_re     <= 1'b0;
            mem_mem_we     <= 1'b0;
            mem_funct3     <= '0;
            mem_wb_sel     <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= taken & ~stall_in;
            if (!stall_in) begin
                mem_valid      <= ev;
                mem_result     <= is_jump ? link_addr : alu_out;
                mem_store_data <= ex_rs2_data;
                mem_rd         <= ex_rd;
                mem_reg_we     <= side_fx_ok & ex_reg_we;
                mem_mem_re     <= side_fx_ok & ex_mem_re;
                mem_mem_we     <= side_fx_ok & ex_mem_we;
                mem_funct3     <= ex_funct3;
                mem_wb_sel     <= ex_wb_sel;
                if (taken) redirect_pc <= target;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_ex_mem_stage;

    bit          clk;
    logic        rst;
    logic        stall_in, flush, ex_valid;
    logic [31:0] ex_pc, ex_imm, alu_out, ex_rs2_data;
    logic        zero, lt_signed, lt_unsigned;
    logic        ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_we, ex_mem_re, ex_mem_we;
    logic [1:0]  ex_wb_sel;

    logic        ex_accept, mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, redirect_valid;
    logic [31:0] mem_result, mem_store_data, redirect_pc;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_wb_sel;

    int total = 0;
    int bad   = 0;

    // Expected architectural view of the MEM-side outputs.
    logic        e_valid, e_reg_we, e_mem_re, e_mem_we, e_rv;
    logic [31:0] e_result, e_store, e_rpc;
    logic [4:0]  e_rd;
    logic [2:0]  e_funct3;
    logic [1:0]  e_wb_sel;
    bit          e_squash_next;

    ex_mem_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .alu_out(alu_out), .zero(zero),
        .lt_signed(lt_signed), .lt_unsigned(lt_unsigned), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3),
        .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_wb_sel(ex_wb_sel),
        .ex_accept(ex_accept), .mem_valid(mem_valid), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we),
        .mem_mem_re(mem_mem_re), .mem_mem_we(mem_mem_we), .mem_funct3(mem_funct3),
        .mem_wb_sel(mem_wb_sel), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    function automatic bit branch_holds(input logic [2:0] f3, input logic z, input logic lts,
                                        input logic ltu);
        case (f3)
            3'd0:    return z;
            3'd1:    return !z;
            3'd4:    return lts;
            3'd5:    return !lts;
            3'd6:    return ltu;
            3'd7:    return !ltu;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        {e_valid, e_reg_we, e_mem_re, e_mem_we, e_rv} = '0;
        e_result = '0; e_store = '0; e_rpc = '0; e_rd = '0; e_funct3 = '0; e_wb_sel = '0;
        e_squash_next = 0;
    endtask

    task automatic idle();
        stall_in = 0; flush = 0; ex_valid = 0;
        ex_pc = '0; ex_imm = '0; alu_out = '0; ex_rs2_data = '0;
        zero = 0; lt_signed = 0; lt_unsigned = 0;
        ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = '0; ex_rd = '0; ex_reg_we = 0; ex_mem_re = 0; ex_mem_we = 0; ex_wb_sel = '0;
    endtask

    // Advance one clock: the model decides what the stage must show after the edge.
    task automatic cycle();
        bit          real_instr, jump, go, writes, hold;
        logic [31:0] dest;
        real_instr = ex_valid && !flush && !e_squash_next;
        jump       = ex_is_jal || ex_is_jalr;
        go         = real_instr && ((ex_is_branch && branch_holds(ex_funct3, zero, lt_signed,
                                                                    lt_unsigned)) || jump);
        writes     = real_instr && !(ex_is_branch && !go);
        dest       = ex_is_jalr ? (alu_out & 32'hFFFF_FFFE) : ex_pc + ex_imm;
        hold       = stall_in;
        @(posedge clk);
        #1;
        e_rv = go && !hold;
        if (!hold) begin
            e_valid  = real_instr;
            e_result = jump ? ex_pc + 32'd4 : alu_out;
            e_store  = ex_rs2_data;
            e_rd     = ex_rd;
            e_reg_we = writes && ex_reg_we;
            e_mem_re = writes && ex_mem_re;
            e_mem_we = writes && ex_mem_we;
            e_funct3 = ex_funct3;
            e_wb_sel = ex_wb_sel;
            if (go) e_rpc = dest;
            e_squash_next = go;
        end
    endtask

    always @(negedge clk) begin
        check("ex_accept",      32'(ex_accept),      32'(!stall_in));
        check("mem_valid",      32'(mem_valid),      32'(e_valid));
        check("mem_result",     mem_result,          e_result);
        check("mem_store_data", mem_store_data,      e_store);
        check("mem_rd",         32'(mem_rd),         32'(e_rd));
        check("mem_reg_we",     32'(mem_reg_we),     32'(e_reg_we));
        check("mem_mem_re",     32'(mem_mem_re),     32'(e_mem_re));
        check("mem_mem_we",     32'(mem_mem_we),     32'(e_mem_we));
        check("mem_funct3",     32'(mem_funct3),     32'(e_funct3));
        check("mem_wb_sel",     32'(mem_wb_sel),     32'(e_wb_sel));
        check("redirect_valid", 32'(redirect_valid), 32'(e_rv));
        check("redirect_pc",    redirect_pc,         e_rpc);
    end

    task automatic check_all_zero(input string tag);
        check({tag, " mem_valid"},      32'(mem_valid), 0);
        check({tag, " mem_result"},     mem_result, 0);
        check({tag, " mem_store_data"}, mem_store_data, 0);
        check({tag, " mem_rd"},         32'(mem_rd), 0);
        check({tag, " enables"},        32'({mem_reg_we, mem_mem_re, mem_mem_we}), 0);
        check({tag, " mem_funct3"},     32'(mem_funct3), 0);
        check({tag, " mem_wb_sel"},     32'(mem_wb_sel), 0);
        check({tag, " redirect_valid"}, 32'(redirect_valid), 0);
        check({tag, " redirect_pc"},    redirect_pc, 0);
    endtask

    task automatic plain(input logic [31:0] res);
        idle(); ex_valid = 1; alu_out = res; ex_reg_we = 1; ex_rd = 5'd7;
        ex_rs2_data = 32'hA5A5_0000 | res; ex_funct3 = 3'd2; ex_wb_sel = 2'd0;
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;

        // Reset release: first instruction flows straight through.
        plain(32'h10); cycle();
        check("after_reset result", mem_result, 32'h10);
        check("after_reset valid",  32'(mem_valid), 1);

        // Reset mid-stream discards the pending squash and redirect.
        idle(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h40; ex_imm = 32'h20; ex_reg_we = 1;
        ex_wb_sel = 2'd2; cycle();
        check("jal redirect_pc", redirect_pc, 32'h60);
        check("jal link",        mem_result, 32'h44);
        plain(32'h77);
        #2 rst = 1;
        #1 model_reset();
        check_all_zero("async_reset");
        @(posedge clk); #1;
        rst = 0;
        cycle();
        check("post_reset not squashed", 32'(mem_valid), 1);
        check("post_reset result",       mem_result, 32'h77);

        // BNE taken with backward target.
        idle(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b001; zero = 0;
        ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0; cycle();
        check("bne redirect_valid", 32'(redirect_valid), 1);
        check("bne redirect_pc",    redirect_pc, 32'hF0);
        idle(); ex_valid = 1; ex_reg_we = 1; ex_mem_re = 1; ex_mem_we = 1; cycle();
        check("bne shadow valid",   32'(mem_valid), 0);
        check("bne shadow enables", 32'({mem_reg_we, mem_mem_re, mem_mem_we}), 0);
        check("bne pulse ends",     32'(redirect_valid), 0);
        check("bne pc held",        redirect_pc, 32'hF0);

        // BGEU not taken retires without side effects.
        idle(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b111; lt_unsigned = 1;
        ex_reg_we = 1; ex_mem_we = 1; cycle();
        check("bgeu no redirect", 32'(redirect_valid), 0);
        check("bgeu valid",       32'(mem_valid), 1);
        check("bgeu reg_we",      32'(mem_reg_we), 0);

        // JALR: target bit 0 cleared, link wraps.
        idle(); ex_valid = 1; ex_is_jalr = 1; alu_out = 32'h2001; ex_pc = 32'hFFFF_FFFC;
        ex_reg_we = 1; ex_wb_sel = 2'd2; cycle();
        check("jalr redirect_pc", redirect_pc, 32'h2000);
        check("jalr link wrap",   mem_result, 32'h0);
        check("jalr reg_we",      32'(mem_reg_we), 1);
        plain(32'h31); cycle();
        check("jalr shadow squashed", 32'(mem_valid), 0);

        // Stall while a squash is pending.
        idle(); ex_valid = 1; ex_is_jal = 1; ex_pc = 32'h200; ex_imm = 32'h100; cycle();
        check("stall jal redirect", redirect_pc, 32'h300);
        plain(32'h55); stall_in = 1;
        repeat (3) begin
            cycle();
            check("stall held result", mem_result, 32'h204);
            check("stall no redirect", 32'(redirect_valid), 0);
        end
        stall_in = 0; cycle();
        check("post_stall squashed", 32'(mem_valid), 0);
        plain(32'h66); cycle();
        check("post_stall passes", 32'(mem_valid), 1);
        check("post_stall result", mem_result, 32'h66);

        // Flush beats a taken branch.
        idle(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000; zero = 1; flush = 1;
        ex_pc = 32'h400; ex_imm = 32'h8; cycle();
        check("flush no redirect", 32'(redirect_valid), 0);
        check("flush bubble",      32'(mem_valid), 0);
        plain(32'h99); cycle();
        check("flush stays run", 32'(mem_valid), 1);

        // Every funct3 against every flag combination.
        for (int f = 0; f < 8; f++) begin
            for (int fl = 0; fl < 8; fl++) begin
                idle(); ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'(f);
                {zero, lt_signed, lt_unsigned} = 3'(fl);
                ex_pc = 32'h1000 + 32'(f * 64 + fl * 4); ex_imm = 32'h40; ex_reg_we = 1;
                cycle();
                plain(32'(fl)); cycle();
            end
        end

        // Random mix including stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            int kind;
            idle();
            kind         = int'($urandom_range(0, 3));
            ex_valid     = ($urandom_range(0, 7) != 0);
            stall_in     = ($urandom_range(0, 4) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            ex_pc        = $urandom; ex_imm = $urandom; alu_out = $urandom;
            ex_rs2_data  = $urandom;
            {zero, lt_signed, lt_unsigned} = 3'($urandom);
            ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
            ex_funct3    = 3'($urandom); ex_rd = 5'($urandom);
            {ex_reg_we, ex_mem_re, ex_mem_we} = 3'($urandom);
            ex_wb_sel    = 2'($urandom);
            cycle();
        end

        idle();
        cycle();
        @(negedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
